// File: rtl/nn_pkg.sv
// Shared definitions for the hidden-neuron weight interface.
// Holds the default layer geometry, the loader state type and the
// per-neuron weight slice width used by both producer and consumer.
package nn_pkg;

    localparam int WEIGHT_W           = 8;  // 1.7 unsigned fixed point
    localparam int WEIGHTS_PER_NEURON = 4;
    localparam int NUM_NEURONS        = 4;

    // Width of one neuron's slice of the flattened weight bus: {w3,w2,w1,w0}
    localparam int NEURON_W = WEIGHTS_PER_NEURON * WEIGHT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/weight_loader.sv
// weight_loader: streams weight bytes into a shadow bank, verifies an
// additive (mod 2^WEIGHT_W) checksum and only then commits the bank to the
// hidden-neuron weight bus, pulsing every neuron enable for one cycle.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        begin / restart a load sequence (ignored in COMMIT)
//   data_i         weight byte, or the checksum byte after TOTAL weights
//   data_valid_i   data_i qualifier
//   busy_o         state != IDLE
//   done_o         one-cycle pulse, first cycle the new weights are visible
//   err_o          sticky checksum error, cleared by start_i or reset
//   weights_o      committed weights; byte k = neuron k/WPN, weight k%WPN
//   neuron_en_o    one-cycle enable to every neuron, aligned with done_o
module weight_loader #(
    parameter int NUM_NEURONS        = nn_pkg::NUM_NEURONS,
    parameter int WEIGHTS_PER_NEURON = nn_pkg::WEIGHTS_PER_NEURON,
    parameter int WEIGHT_W           = nn_pkg::WEIGHT_W
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             start_i,
    input  logic [WEIGHT_W-1:0]                              data_i,
    input  logic                                             data_valid_i,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             err_o,
    output logic [NUM_NEURONS*WEIGHTS_PER_NEURON*WEIGHT_W-1:0] weights_o,
    output logic [NUM_NEURONS-1:0]                           neuron_en_o
);
    import nn_pkg::*;

    localparam int TOTAL = NUM_NEURONS * WEIGHTS_PER_NEURON;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

    state_t state, state_next;

    // Packed so that byte k lands at bits [k*WEIGHT_W +: WEIGHT_W],
    // which is exactly the neuron/weight layout of weights_o.
    logic [TOTAL-1:0][WEIGHT_W-1:0] shadow;
    logic [TOTAL-1:0][WEIGHT_W-1:0] weights;
    logic [CNT_W-1:0]               cnt;
    logic [WEIGHT_W-1:0]            sum;
    logic                           err;
    logic                           done;
    logic [NUM_NEURONS-1:0]         neuron_en;

    logic restart, take_byte, take_chk, chk_ok;

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        take_byte  = 1'b0;
        take_chk   = 1'b0;
        chk_ok     = (data_i == sum);
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // start_i wins over a simultaneous byte, which is dropped
                if (start_i) begin
                    restart = 1'b1;
                end else if (data_valid_i) begin
                    if (cnt < CNT_FULL) begin
                        take_byte = 1'b1;
                    end else begin
                        take_chk   = 1'b1;
                        state_next = chk_ok ? COMMIT : IDLE;
                    end
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow    <= '0;
            weights   <= '0;
            cnt       <= '0;
            sum       <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            neuron_en <= '0;
        end else begin
            // Registered so the pulse coincides with the new weights_o
            done      <= (state == COMMIT);
            neuron_en <= {NUM_NEURONS{state == COMMIT}};

            if (restart) begin
                cnt <= '0;
                sum <= '0;
                err <= 1'b0;
            end

            if (take_byte) begin
                for (int k = 0; k < TOTAL; k++) begin
                    if (cnt == CNT_W'(k)) shadow[k] <= data_i;
                end
                cnt <= cnt + 1'b1;
                sum <= sum + data_i;
            end

            if (take_chk && !chk_ok) err <= 1'b1;

            if (state == COMMIT) weights <= shadow;
        end
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = done;
    assign err_o       = err;
    assign weights_o   = weights;
    assign neuron_en_o = neuron_en;

endmodule
